// File: rtl/video_pkg.sv
// Shared definitions for the video mode controller: FSM encoding, resolution
// indices and the timing preset table.
package video_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_WAIT_VS = 3'd1,
    ST_BLANK   = 3'd2,
    ST_APPLY   = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  localparam logic [1:0] RES_800X600  = 2'd0;
  localparam logic [1:0] RES_1024X768 = 2'd1;
  localparam logic [1:0] RES_1280X720 = 2'd2;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_bporch;
    logic [11:0] h_res;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_bporch;
    logic [11:0] v_res;
    logic        hs_pol;
    logic        vs_pol;
  } timing_t;

  localparam timing_t PRESET_800X600 = '{
    h_total: 12'd1056, h_sync: 12'd128, h_bporch: 12'd88, h_res: 12'd800,
    v_total: 12'd628, v_sync: 12'd4, v_bporch: 12'd23, v_res: 12'd600,
    hs_pol: 1'b1, vs_pol: 1'b1};

  localparam timing_t PRESET_1024X768 = '{
    h_total: 12'd1344, h_sync: 12'd136, h_bporch: 12'd160, h_res: 12'd1024,
    v_total: 12'd806, v_sync: 12'd6, v_bporch: 12'd29, v_res: 12'd768,
    hs_pol: 1'b0, vs_pol: 1'b0};

  localparam timing_t PRESET_1280X720 = '{
    h_total: 12'd1650, h_sync: 12'd40, h_bporch: 12'd220, h_res: 12'd1280,
    v_total: 12'd750, v_sync: 12'd5, v_bporch: 12'd20, v_res: 12'd720,
    hs_pol: 1'b1, vs_pol: 1'b1};

  // Index 3 never occurs in normal operation; it falls back to 1280x720.
  function automatic timing_t preset_lookup(input logic [1:0] idx);
    case (idx)
      RES_800X600:  return PRESET_800X600;
      RES_1024X768: return PRESET_1024X768;
      default:      return PRESET_1280X720;
    endcase
  endfunction

  function automatic logic [1:0] next_res(input logic [1:0] idx);
    return (idx >= RES_1280X720) ? RES_800X600 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-time counter and a
// single-cycle press pulse that re-arms only after a stable release.
module key_debounce #(
  parameter logic [19:0] P_DB_CNT = 20'd742500
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_key_n,
  output logic O_press
);

  logic        key_p0;
  logic        key_p1;
  logic        armed;
  logic [19:0] cnt;

  // armed: counting consecutive low samples; disarmed: counting high samples.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      key_p0  <= 1'b1;
      key_p1  <= 1'b1;
      armed   <= 1'b1;
      cnt     <= '0;
      O_press <= 1'b0;
    end else begin
      key_p0  <= I_key_n;
      key_p1  <= key_p0;
      O_press <= 1'b0;
      if (armed ? !key_p1 : key_p1) begin
        if (cnt == P_DB_CNT - 20'd1) begin
          cnt     <= '0;
          armed   <= !armed;
          O_press <= armed;
        end else begin
          cnt <= cnt + 20'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/video_mode_ctrl.sv
// Video mode controller: key-driven resolution switching with VS-aligned
// blanking and timing-generator reset, plus an auto-advancing pattern mode.
module video_mode_ctrl
  import video_pkg::*;
#(
  parameter logic [19:0] P_DB_CNT       = 20'd742500,
  parameter logic [9:0]  P_AUTO_FRAMES  = 10'd256,
  parameter logic [2:0]  P_BLANK_FRAMES = 3'd2,
  parameter logic [4:0]  P_HOLD_CYC     = 5'd16,
  parameter logic [23:0] P_VS_TIMEOUT   = 24'd2000000,
  parameter logic [1:0]  P_RES_INIT     = 2'd2
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_key_n,
  input  logic        I_auto_en,
  input  logic        I_vs,
  output logic [11:0] O_h_total,
  output logic [11:0] O_h_sync,
  output logic [11:0] O_h_bporch,
  output logic [11:0] O_h_res,
  output logic [11:0] O_v_total,
  output logic [11:0] O_v_sync,
  output logic [11:0] O_v_bporch,
  output logic [11:0] O_v_res,
  output logic        O_hs_pol,
  output logic        O_vs_pol,
  output logic [2:0]  O_mode,
  output logic [1:0]  O_res_sel,
  output logic        O_tg_rst_n,
  output logic        O_blank,
  output logic        O_busy
);

  state_t      state;
  timing_t     timing;
  logic [1:0]  res_sel;
  logic [1:0]  next_idx;
  logic [1:0]  mode_cnt;
  logic [9:0]  frame_cnt;
  logic [2:0]  blank_cnt;
  logic [4:0]  hold_cnt;
  logic [23:0] to_cnt;
  logic        vs_p0;
  logic        vs_p1;
  logic        vs_fall;
  logic        press;
  logic        tg_rst_n;
  logic        blank;
  logic        busy;

  key_debounce #(.P_DB_CNT(P_DB_CNT)) u_key_debounce (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_key_n (I_key_n),
    .O_press (press)
  );

  // VS edge detect: vs_p0 is the current registered sample, vs_p1 the previous.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_p0 <= 1'b0;
      vs_p1 <= 1'b0;
    end else begin
      vs_p0 <= I_vs;
      vs_p1 <= vs_p0;
    end
  end

  assign vs_fall = vs_p1 & ~vs_p0;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      frame_cnt <= '0;
      mode_cnt  <= '0;
    end else if (state == ST_APPLY) begin
      frame_cnt <= '0;
    end else if (state == ST_RUN && I_auto_en && vs_fall) begin
      if (frame_cnt == P_AUTO_FRAMES - 10'd1) begin
        frame_cnt <= '0;
        mode_cnt  <= mode_cnt + 2'd1;
      end else begin
        frame_cnt <= frame_cnt + 10'd1;
      end
    end
  end

  // Outputs are registered alongside the state, so each transition sets the
  // values the destination state must present on its first cycle.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state     <= ST_RUN;
      timing    <= preset_lookup(P_RES_INIT);
      res_sel   <= P_RES_INIT;
      next_idx  <= P_RES_INIT;
      tg_rst_n  <= 1'b0;
      blank     <= 1'b1;
      busy      <= 1'b0;
      to_cnt    <= '0;
      blank_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          tg_rst_n <= 1'b1;
          blank    <= 1'b0;
          busy     <= 1'b0;
          if (press) begin
            state    <= ST_WAIT_VS;
            next_idx <= next_res(res_sel);
            busy     <= 1'b1;
            to_cnt   <= '0;
          end
        end
        ST_WAIT_VS: begin
          if (vs_fall) begin
            state     <= ST_BLANK;
            blank     <= 1'b1;
            to_cnt    <= '0;
            blank_cnt <= '0;
          end else if (to_cnt == P_VS_TIMEOUT - 24'd1) begin
            state    <= ST_APPLY;
            blank    <= 1'b1;
            tg_rst_n <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 24'd1;
          end
        end
        // Frames are counted from the edges seen after blanking started.
        ST_BLANK: begin
          if (vs_fall) begin
            to_cnt <= '0;
            if (blank_cnt == P_BLANK_FRAMES - 3'd1) begin
              state    <= ST_APPLY;
              tg_rst_n <= 1'b0;
            end else begin
              blank_cnt <= blank_cnt + 3'd1;
            end
          end else if (to_cnt == P_VS_TIMEOUT - 24'd1) begin
            state    <= ST_APPLY;
            tg_rst_n <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 24'd1;
          end
        end
        ST_APPLY: begin
          timing   <= preset_lookup(next_idx);
          res_sel  <= next_idx;
          hold_cnt <= '0;
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt == P_HOLD_CYC - 5'd1) begin
            state    <= ST_RUN;
            tg_rst_n <= 1'b1;
            blank    <= 1'b0;
            busy     <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 5'd1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign O_h_total  = timing.h_total;
  assign O_h_sync   = timing.h_sync;
  assign O_h_bporch = timing.h_bporch;
  assign O_h_res    = timing.h_res;
  assign O_v_total  = timing.v_total;
  assign O_v_sync   = timing.v_sync;
  assign O_v_bporch = timing.v_bporch;
  assign O_v_res    = timing.v_res;
  assign O_hs_pol   = timing.hs_pol;
  assign O_vs_pol   = timing.vs_pol;
  assign O_mode     = {1'b0, mode_cnt};
  assign O_res_sel  = res_sel;
  assign O_tg_rst_n = tg_rst_n;
  assign O_blank    = blank;
  assign O_busy     = busy;

endmodule
